// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: a small circular FIFO whose
// IF-facing ready depends only on registered occupancy.
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h03400000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_inst,
    input  logic                         in_has_exception,
    input  logic [5:0]                   in_ecode,
    input  logic [8:0]                   in_esubcode,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_inst,
    output logic                         out_has_exception,
    output logic [5:0]                   out_ecode,
    output logic [8:0]                   out_esubcode,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int              PW         = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]     ZERO_COUNT = '0;
    localparam logic [PW:0]     CNT_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   occ;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic        exc_mem  [DEPTH];
    logic [5:0]  ecode_mem[DEPTH];
    logic [8:0]  esub_mem [DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] store_inst;

    // Ready comes from registered occupancy only, cutting the ID stall path to IF.
    assign in_ready  = (occ != FULL_COUNT);
    assign out_valid = (occ != ZERO_COUNT);
    assign count     = occ;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign store_inst = in_has_exception ? NOP_INST : in_inst;

    assign out_pc            = pc_mem[rp];
    assign out_inst          = inst_mem[rp];
    assign out_has_exception = exc_mem[rp];
    assign out_ecode         = ecode_mem[rp];
    assign out_esubcode      = esub_mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                inst_mem[i]  <= '0;
                exc_mem[i]   <= 1'b0;
                ecode_mem[i] <= '0;
                esub_mem[i]  <= '0;
            end
        end else if (flush) begin
            // Slot contents are left in place; only the bookkeeping is cleared.
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (push) begin
                pc_mem[wp]    <= in_pc;
                inst_mem[wp]  <= store_inst;
                exc_mem[wp]   <= in_has_exception;
                ecode_mem[wp] <= in_ecode;
                esub_mem[wp]  <= in_esubcode;
                wp            <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=2) plus a streaming wrap sequence.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_has_exception;
    logic [5:0]  in_ecode;
    logic [8:0]  in_esubcode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_has_exception;
    logic [5:0]  out_ecode;
    logic [8:0]  out_esubcode;
    logic [1:0]  count;

    int checks_total;
    int checks_passed;

    fetch_queue #(.DEPTH(2), .NOP_INST(32'h03400000)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pc             (in_pc),
        .in_inst           (in_inst),
        .in_has_exception  (in_has_exception),
        .in_ecode          (in_ecode),
        .in_esubcode       (in_esubcode),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_has_exception (out_has_exception),
        .out_ecode         (out_ecode),
        .out_esubcode      (out_esubcode),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic        flush;
        logic        out_ready;
        logic        exc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        e_ready;
        logic        e_valid;
        logic [1:0]  e_count;
        logic        chk_payload;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_exc;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(
        input logic rst_i, input logic valid_i, input logic flush_i, input logic ready_i,
        input logic exc_i, input logic [31:0] pc_i, input logic [31:0] inst_i,
        input logic [5:0] ecode_i, input logic [8:0] esub_i,
        input logic e_ready_i, input logic e_valid_i, input logic [1:0] e_count_i,
        input logic chk_i, input logic [31:0] e_pc_i, input logic [31:0] e_inst_i,
        input logic e_exc_i, input logic [5:0] e_ecode_i, input logic [8:0] e_esub_i);
        vec_t v;
        v.rst = rst_i;       v.in_valid = valid_i;  v.flush = flush_i;  v.out_ready = ready_i;
        v.exc = exc_i;       v.pc = pc_i;           v.inst = inst_i;
        v.ecode = ecode_i;   v.esub = esub_i;
        v.e_ready = e_ready_i; v.e_valid = e_valid_i; v.e_count = e_count_i;
        v.chk_payload = chk_i; v.e_pc = e_pc_i;     v.e_inst = e_inst_i;
        v.e_exc = e_exc_i;   v.e_ecode = e_ecode_i; v.e_esub = e_esub_i;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst              = v.rst;
        in_valid         = v.in_valid;
        flush            = v.flush;
        out_ready        = v.out_ready;
        in_has_exception = v.exc;
        in_pc            = v.pc;
        in_inst          = v.inst;
        in_ecode         = v.ecode;
        in_esubcode      = v.esub;
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled 1ns after the edge, i.e. the state seen during the next cycle.
    task automatic checkOutput(input vec_t v, input string tag);
        checkField({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, v.e_ready});
        checkField({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.e_valid});
        checkField({tag, " count"},     {30'd0, count},     {30'd0, v.e_count});
        if (v.chk_payload) begin
            checkField({tag, " out_pc"},       out_pc,                     v.e_pc);
            checkField({tag, " out_inst"},     out_inst,                   v.e_inst);
            checkField({tag, " out_has_exc"},  {31'd0, out_has_exception}, {31'd0, v.e_exc});
            checkField({tag, " out_ecode"},    {26'd0, out_ecode},         {26'd0, v.e_ecode});
            checkField({tag, " out_esubcode"}, {23'd0, out_esubcode},      {23'd0, v.e_esub});
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_has_exception = 1'b0; in_pc = '0; in_inst = '0; in_ecode = '0; in_esubcode = '0;

        //         rst v  fl or ex pc            inst          ec    es    | rdy val cnt chk e_pc          e_inst        ex ec    es
        vecs.push_back(mkVec(1, 0, 0, 0, 0, 32'h0,        32'h0,        6'h0, 9'h0, 1, 0, 2'd0, 1, 32'h0,        32'h0,        0, 6'h0, 9'h0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h1c000000, 32'h02800401, 6'h0, 9'h0, 1, 1, 2'd1, 1, 32'h1c000000, 32'h02800401, 0, 6'h0, 9'h0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h1c000004, 32'h02800402, 6'h0, 9'h0, 0, 1, 2'd2, 1, 32'h1c000000, 32'h02800401, 0, 6'h0, 9'h0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h1c000008, 32'h02800403, 6'h0, 9'h0, 0, 1, 2'd2, 1, 32'h1c000000, 32'h02800401, 0, 6'h0, 9'h0));
        // Pop while full: the offered beat must not be taken because in_ready is still 0.
        vecs.push_back(mkVec(0, 1, 0, 1, 0, 32'h1c000008, 32'h02800403, 6'h0, 9'h0, 1, 1, 2'd1, 1, 32'h1c000004, 32'h02800402, 0, 6'h0, 9'h0));
        vecs.push_back(mkVec(0, 0, 0, 1, 0, 32'h0,        32'h0,        6'h0, 9'h0, 1, 0, 2'd0, 0, 32'h0,        32'h0,        0, 6'h0, 9'h0));
        vecs.push_back(mkVec(0, 1, 0, 0, 1, 32'h1c000002, 32'hdeadbeef, 6'h8, 9'h0, 1, 1, 2'd1, 1, 32'h1c000002, 32'h03400000, 1, 6'h8, 9'h0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h1c000010, 32'h00000011, 6'h0, 9'h0, 0, 1, 2'd2, 1, 32'h1c000002, 32'h03400000, 1, 6'h8, 9'h0));
        vecs.push_back(mkVec(0, 1, 1, 1, 0, 32'h1c000014, 32'h00000015, 6'h0, 9'h0, 1, 0, 2'd0, 0, 32'h0,        32'h0,        0, 6'h0, 9'h0));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, 32'h1c008000, 32'h12345678, 6'h0, 9'h0, 1, 1, 2'd1, 1, 32'h1c008000, 32'h12345678, 0, 6'h0, 9'h0));
        vecs.push_back(mkVec(1, 1, 0, 0, 0, 32'h1c00800c, 32'h0badf00d, 6'h0, 9'h0, 1, 0, 2'd0, 1, 32'h0,        32'h0,        0, 6'h0, 9'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Streaming through the wrap: each edge pops entry i-1 and pushes entry i.
        for (int i = 0; i < 8; i++) begin
            vec_t s;
            s = mkVec(0, 1, 0, 1, 0, 32'h1c000000 + 32'(4 * i), 32'h00001000 + 32'(i), 6'h0, 9'h0,
                      1, 1, 2'd1, 1, 32'h1c000000 + 32'(4 * i), 32'h00001000 + 32'(i), 0, 6'h0, 9'h0);
            applyStimulus(s);
            checkOutput(s, $sformatf("stream%0d", i));
        end
        begin
            vec_t d;
            d = mkVec(0, 0, 0, 1, 0, 32'h0, 32'h0, 6'h0, 9'h0, 1, 0, 2'd0, 0, 32'h0, 32'h0, 0, 6'h0, 9'h0);
            applyStimulus(d);
            checkOutput(d, "stream_drain");
        end

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
